// File: rtl/lbm_mem_pkg.sv
// Shared types and the saturating adder for the LBM moment memories.
package lbm_mem_pkg;

    typedef enum logic {
        WR_OVERWRITE = 1'b0,
        WR_ACCUM     = 1'b1
    } wr_mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        SWEEP = 2'd2
    } clr_state_t;

    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_BANK = 2'd1,
        RD_FWD  = 2'd2
    } rd_src_t;

    // Operands are sign-extended into this width so any channel width up to 63 bits works.
    localparam int SUM_W = 64;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic             ovf;
    } sat_res_t;

    function automatic sat_res_t sat_add(
        input logic signed [SUM_W-1:0] a,
        input logic signed [SUM_W-1:0] b,
        input int                      dw,
        input logic                    sat
    );
        logic signed [SUM_W-1:0] s;
        logic signed [SUM_W-1:0] vmax;
        logic signed [SUM_W-1:0] vmin;
        sat_res_t                r;
        s    = a + b;
        vmax = (64'sd1 <<< (dw - 1)) - 64'sd1;
        vmin = -(64'sd1 <<< (dw - 1));
        if (s > vmax) begin
            r.ovf = 1'b1;
            r.sum = sat ? vmax : s;
        end else if (s < vmin) begin
            r.ovf = 1'b1;
            r.sum = sat ? vmin : s;
        end else begin
            r.ovf = 1'b0;
            r.sum = s;
        end
        return r;
    endfunction

endpackage

// File: rtl/moment_ram_bank.sv
// One moment channel: DEPTH x DATA_WIDTH storage with a write port and two synchronous read ports.
module moment_ram_bank #(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 32
) (
    input  logic                     Clk,
    input  logic                     i_we,
    input  logic [ADDRESS_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [ADDRESS_WIDTH-1:0] i_rmw_addr,
    output logic [DATA_WIDTH-1:0]    o_rmw_data,
    input  logic                     i_rd_en,
    input  logic [ADDRESS_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]    o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    // Storage write; left without reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Internal read feeding the read-modify-write stage.
    always_ff @(posedge Clk) begin
        o_rmw_data <= r_mem[i_rmw_addr];
    end

    // External read; holds its value between accepted reads.
    always_ff @(posedge Clk) begin
        if (i_rd_en) begin
            o_rd_data <= r_mem[i_rd_addr];
        end
    end

endmodule

// File: rtl/moment_ram_mc.sv
// Multi-channel moment store: masked overwrite/accumulate write pipeline with
// forwarding, latency-1 read port and a hardware clear sweep.
module moment_ram_mc
    import lbm_mem_pkg::*;
#(
    parameter int DEPTH         = 256,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH),
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_CH        = 3,
    parameter int SATURATE      = 1
) (
    input  logic                           Clk,
    input  logic                           Reset,
    input  logic                           clear_start,
    output logic                           busy,
    input  logic                           wr_valid,
    output logic                           wr_ready,
    input  logic                           wr_mode,
    input  logic [ADDRESS_WIDTH-1:0]       wr_addr,
    input  logic [NUM_CH-1:0]              wr_mask,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   wr_data,
    input  logic                           rd_en,
    input  logic [ADDRESS_WIDTH-1:0]       rd_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   rd_data,
    output logic                           rd_valid,
    output logic [NUM_CH-1:0]              sat_flag
);

    localparam int PW = NUM_CH * DATA_WIDTH;

    function automatic logic in_range(input logic [ADDRESS_WIDTH-1:0] a);
        return (32'(a) < 32'(DEPTH));
    endfunction

    clr_state_t                r_state;
    logic [ADDRESS_WIDTH-1:0]  r_clr_addr;
    logic                      r_busy;
    logic                      r_wr_ready;
    logic [NUM_CH-1:0]         r_sat_flag;

    logic                      r_s1_valid;
    logic [ADDRESS_WIDTH-1:0]  r_s1_addr;
    wr_mode_t                  r_s1_mode;
    logic [NUM_CH-1:0]         r_s1_mask;
    logic [PW-1:0]             r_s1_data;
    logic                      r_fwd_hit;
    logic [PW-1:0]             r_fwd_data;

    rd_src_t                   r_rd_src;
    logic [PW-1:0]             r_rd_fwd_data;
    logic                      r_rd_valid;

    logic                      w_wr_acc;
    logic                      w_rd_acc;
    logic [PW-1:0]             w_rmw_data;
    logic [PW-1:0]             w_bank_rd;
    logic [PW-1:0]             w_merged;
    logic [NUM_CH-1:0]         w_ovf;
    logic [NUM_CH-1:0]         w_sat_set;
    logic [NUM_CH-1:0]         w_we;
    logic [ADDRESS_WIDTH-1:0]  w_waddr;
    logic [PW-1:0]             w_wdata;

    assign w_wr_acc = wr_valid & r_wr_ready;
    assign w_rd_acc = rd_en & ~r_busy;
    assign busy     = r_busy;
    assign wr_ready = r_wr_ready;
    assign rd_valid = r_rd_valid;
    assign sat_flag = r_sat_flag;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_bank
        moment_ram_bank #(
            .DEPTH         (DEPTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DATA_WIDTH    (DATA_WIDTH)
        ) u_bank (
            .Clk        (Clk),
            .i_we       (w_we[c]),
            .i_waddr    (w_waddr),
            .i_wdata    (w_wdata[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_rmw_addr (wr_addr),
            .o_rmw_data (w_rmw_data[c*DATA_WIDTH +: DATA_WIDTH]),
            .i_rd_en    (w_rd_acc),
            .i_rd_addr  (rd_addr),
            .o_rd_data  (w_bank_rd[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end

    // S1 merge: old operand comes from the previous S1 result when it targeted the same node.
    always_comb begin : merge_p
        logic [DATA_WIDTH-1:0] v_old;
        logic [DATA_WIDTH-1:0] v_dat;
        sat_res_t              v_res;
        v_old    = '0;
        v_dat    = '0;
        v_res    = '0;
        w_merged = '0;
        w_ovf    = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            v_old = r_fwd_hit ? r_fwd_data[c*DATA_WIDTH +: DATA_WIDTH]
                              : w_rmw_data[c*DATA_WIDTH +: DATA_WIDTH];
            v_dat = r_s1_data[c*DATA_WIDTH +: DATA_WIDTH];
            v_res = sat_add({{(SUM_W-DATA_WIDTH){v_old[DATA_WIDTH-1]}}, v_old},
                            {{(SUM_W-DATA_WIDTH){v_dat[DATA_WIDTH-1]}}, v_dat},
                            DATA_WIDTH, SATURATE != 0);
            if (!r_s1_mask[c]) begin
                w_merged[c*DATA_WIDTH +: DATA_WIDTH] = v_old;
            end else if (r_s1_mode == WR_ACCUM) begin
                w_merged[c*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(v_res.sum);
                w_ovf[c] = v_res.ovf;
            end else begin
                w_merged[c*DATA_WIDTH +: DATA_WIDTH] = v_dat;
            end
        end
    end

    // Bank write port: the sweep owns it while clearing, otherwise the S1 commit.
    always_comb begin
        if (r_state == SWEEP) begin
            w_we    = '1;
            w_waddr = r_clr_addr;
            w_wdata = '0;
        end else begin
            w_we    = (r_s1_valid && in_range(r_s1_addr)) ? r_s1_mask : '0;
            w_waddr = r_s1_addr;
            w_wdata = w_merged;
        end
        if ((SATURATE != 0) && r_s1_valid && in_range(r_s1_addr)) begin
            w_sat_set = w_ovf;
        end else begin
            w_sat_set = '0;
        end
    end

    // Pipeline control bits.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_s1_valid <= 1'b0;
            r_fwd_hit  <= 1'b0;
        end else begin
            r_s1_valid <= w_wr_acc;
            r_fwd_hit  <= w_wr_acc && r_s1_valid && (r_s1_addr == wr_addr);
        end
    end

    // S0 capture of the accepted write and the forwarding copy of the S1 result.
    always_ff @(posedge Clk) begin
        r_fwd_data <= w_merged;
        if (w_wr_acc) begin
            r_s1_addr <= wr_addr;
            r_s1_mode <= wr_mode_t'(wr_mode);
            r_s1_mask <= wr_mask;
            r_s1_data <= wr_data;
        end
    end

    // Read port: select zero, bank or the in-flight S1 value for the result.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rd_valid <= 1'b0;
            r_rd_src   <= RD_ZERO;
        end else if (w_rd_acc) begin
            r_rd_valid    <= 1'b1;
            r_rd_fwd_data <= w_merged;
            if (!in_range(rd_addr)) begin
                r_rd_src <= RD_ZERO;
            end else if (r_s1_valid && (r_s1_addr == rd_addr)) begin
                r_rd_src <= RD_FWD;
            end else begin
                r_rd_src <= RD_BANK;
            end
        end else begin
            r_rd_valid <= 1'b0;
        end
    end

    // Read data mux over registered sources.
    always_comb begin
        case (r_rd_src)
            RD_BANK: rd_data = w_bank_rd;
            RD_FWD:  rd_data = r_rd_fwd_data;
            RD_ZERO: rd_data = '0;
            default: rd_data = '0;
        endcase
    end

    // Clear FSM: DRAIN lets the last S1 write land, SWEEP zero-fills one node per cycle.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
            r_clr_addr <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (clear_start) begin
                        r_state    <= DRAIN;
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                DRAIN: begin
                    r_state    <= SWEEP;
                    r_clr_addr <= '0;
                end
                SWEEP: begin
                    if (32'(r_clr_addr) == 32'(DEPTH - 1)) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_wr_ready <= 1'b1;
                    end else begin
                        r_clr_addr <= r_clr_addr + ADDRESS_WIDTH'(1);
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Sticky saturation flags, wiped by the sweep.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sat_flag <= '0;
        end else if (r_state == SWEEP) begin
            r_sat_flag <= '0;
        end else begin
            r_sat_flag <= r_sat_flag | w_sat_set;
        end
    end

endmodule

// File: tb/tb_moment_ram_mc.sv
// Directed self-checking bench for moment_ram_mc (saturating and wrapping builds).
module tb_moment_ram_mc;

    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int NCH   = 3;
    localparam int PW    = NCH * DW;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           clear_start = 1'b0;
    logic           wr_valid = 1'b0;
    logic           wr_mode = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [NCH-1:0] wr_mask = '0;
    logic [PW-1:0]  wr_data = '0;
    logic           rd_en = 1'b0;
    logic [AW-1:0]  rd_addr = '0;

    logic           busy, wr_ready, rd_valid;
    logic [PW-1:0]  rd_data;
    logic [NCH-1:0] sat_flag;
    logic           busy_w, wr_ready_w, rd_valid_w;
    logic [PW-1:0]  rd_data_w;
    logic [NCH-1:0] sat_flag_w;

    int n_checks = 0;
    int n_errors = 0;

    always #5 Clk = ~Clk;

    moment_ram_mc #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_CH(NCH), .SATURATE(1)) u_dut (
        .Clk(Clk), .Reset(Reset), .clear_start(clear_start), .busy(busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .sat_flag(sat_flag)
    );

    moment_ram_mc #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_CH(NCH), .SATURATE(0)) u_dut_wrap (
        .Clk(Clk), .Reset(Reset), .clear_start(clear_start), .busy(busy_w),
        .wr_valid(wr_valid), .wr_ready(wr_ready_w), .wr_mode(wr_mode), .wr_addr(wr_addr),
        .wr_mask(wr_mask), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_w), .rd_valid(rd_valid_w), .sat_flag(sat_flag_w)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge Clk);
    endtask

    task automatic do_write(input logic mode, input logic [AW-1:0] addr,
                            input logic [NCH-1:0] mask, input logic [PW-1:0] data);
        wr_valid = 1'b1;
        wr_mode  = mode;
        wr_addr  = addr;
        wr_mask  = mask;
        wr_data  = data;
        cyc();
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] addr, output logic [PW-1:0] data, output logic v);
        rd_en   = 1'b1;
        rd_addr = addr;
        cyc();
        rd_en = 1'b0;
        data  = rd_data;
        v     = rd_valid;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [PW-1:0] d;
        logic          v;
        int            busy_cycles;
        int            bad_rdy;
        int            bad_rv;
        logic [AW-1:0] zaddr [0:8];

        zaddr = '{8'h12, 8'h07, 8'h20, 8'h21, 8'h30, 8'h40, 8'h41, 8'h00, 8'hFF};

        // Reset state
        repeat (3) cyc();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_wr_ready", wr_ready, 1'b1);
        check_eq("rst_rd_valid", rd_valid, 1'b0);
        check_eq("rst_rd_data", rd_data, '0);
        check_eq("rst_sat_flag", sat_flag, 3'b000);
        check_eq("rst_wrap_idle", {busy_w, wr_ready_w, rd_valid_w}, 3'b010);
        Reset = 1'b0;
        cyc();

        // Overwrite then read from the RAM
        do_write(1'b0, 8'h12, 3'b111, {32'h1234_5678, 32'hABCC_CDEF, 32'h0000_0001});
        cyc();
        do_read(8'h12, d, v);
        check_eq("ovw_valid", v, 1'b1);
        check_eq("ovw_data", d, {32'h1234_5678, 32'hABCC_CDEF, 32'h0000_0001});
        cyc();
        check_eq("ovw_valid_drop", rd_valid, 1'b0);
        check_eq("ovw_data_hold", rd_data, {32'h1234_5678, 32'hABCC_CDEF, 32'h0000_0001});

        // Back-to-back accumulates at full rate with forwarding
        do_write(1'b0, 8'h07, 3'b111, {32'd0, 32'd0, 32'd10});
        wr_valid = 1'b1;
        wr_mode  = 1'b1;
        wr_addr  = 8'h07;
        wr_mask  = 3'b001;
        wr_data  = {32'd0, 32'd0, 32'd5};
        repeat (4) cyc();
        wr_valid = 1'b0;
        do_read(8'h07, d, v);
        check_eq("acc_fwd_data", d, {32'd0, 32'd0, 32'd30});
        check_eq("acc_no_sat", sat_flag, 3'b000);

        // Read and same-address write in one cycle returns the old value
        wr_valid = 1'b1; wr_mode = 1'b0; wr_addr = 8'h07; wr_mask = 3'b111;
        wr_data  = {32'd0, 32'd0, 32'd99};
        rd_en = 1'b1; rd_addr = 8'h07;
        cyc();
        wr_valid = 1'b0; rd_en = 1'b0;
        check_eq("rw_same_pre", rd_data, {32'd0, 32'd0, 32'd30});
        cyc();
        do_read(8'h07, d, v);
        check_eq("rw_same_post", d, {32'd0, 32'd0, 32'd99});

        // Positive saturation on ch1
        do_write(1'b0, 8'h20, 3'b111, {32'd0, 32'h7FFF_FFF0, 32'd0});
        do_write(1'b1, 8'h20, 3'b010, {32'd0, 32'h0000_0020, 32'd0});
        cyc();
        do_read(8'h20, d, v);
        check_eq("sat_pos_data", d, {32'd0, 32'h7FFF_FFFF, 32'd0});
        check_eq("sat_pos_flag", sat_flag, 3'b010);
        check_eq("wrap_pos_data", rd_data_w, {32'd0, 32'h8000_0010, 32'd0});
        check_eq("wrap_pos_flag", sat_flag_w, 3'b000);

        // Negative saturation on ch0, read straight out of S1
        do_write(1'b0, 8'h21, 3'b111, {32'd0, 32'd0, 32'h8000_0005});
        do_write(1'b1, 8'h21, 3'b001, {32'd0, 32'd0, 32'hFFFF_FFF0});
        do_read(8'h21, d, v);
        check_eq("sat_neg_data", d, {32'd0, 32'd0, 32'h8000_0000});
        check_eq("wrap_neg_data", rd_data_w, {32'd0, 32'd0, 32'h7FFF_FFF5});
        cyc();
        check_eq("sat_neg_flag", sat_flag, 3'b011);
        check_eq("wrap_neg_flag", sat_flag_w, 3'b000);

        // Mask keeps ch1
        do_write(1'b0, 8'h30, 3'b111, {32'd1, 32'd2, 32'd3});
        do_write(1'b0, 8'h30, 3'b101, {3{32'hFFFF_FFFF}});
        cyc();
        do_read(8'h30, d, v);
        check_eq("mask_data", d, {32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF});

        // Clear sweep with a write in flight; writes, reads and a second clear_start are ignored while busy
        clear_start = 1'b1;
        wr_valid = 1'b1; wr_mode = 1'b0; wr_addr = 8'h40; wr_mask = 3'b111;
        wr_data  = {32'hA, 32'hB, 32'hC};
        cyc();
        clear_start = 1'b0;
        wr_addr = 8'h41;
        rd_en = 1'b1; rd_addr = 8'h12;
        busy_cycles = 0; bad_rdy = 0; bad_rv = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            if (busy !== 1'b1) break;
            busy_cycles++;
            if (wr_ready !== 1'b0) bad_rdy++;
            if (rd_valid !== 1'b0) bad_rv++;
            clear_start = (i == 50);
            cyc();
        end
        wr_valid = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
        check_eq("clr_busy_cycles", busy_cycles, DEPTH + 1);
        check_eq("clr_wr_ready_low", bad_rdy, 0);
        check_eq("clr_rd_valid_low", bad_rv, 0);
        cyc();
        check_eq("clr_busy_done", busy, 1'b0);
        check_eq("clr_sat_flag", sat_flag, 3'b000);
        for (int k = 0; k < 9; k++) begin
            do_read(zaddr[k], d, v);
            check_eq($sformatf("clr_zero_%0h", zaddr[k]), {v, d}, {1'b1, {PW{1'b0}}});
        end

        // Reset in the middle of a sweep
        do_write(1'b0, 8'd50, 3'b111, {32'd4, 32'd5, 32'd6});
        do_write(1'b0, 8'd200, 3'b111, {32'd7, 32'd8, 32'd9});
        cyc();
        do_read(8'd200, d, v);
        check_eq("pre_rst_node200", d, {32'd7, 32'd8, 32'd9});
        clear_start = 1'b1;
        cyc();
        clear_start = 1'b0;
        check_eq("rst_sweep_busy", busy, 1'b1);
        repeat (101) cyc();
        Reset = 1'b1;
        cyc();
        check_eq("rst_sweep_busy_low", busy, 1'b0);
        check_eq("rst_sweep_wr_ready", wr_ready, 1'b1);
        check_eq("rst_sweep_rd_data", rd_data, '0);
        Reset = 1'b0;
        do_read(8'd50, d, v);
        check_eq("rst_sweep_node50", d, '0);
        do_read(8'd200, d, v);
        check_eq("rst_sweep_node200", d, {32'd7, 32'd8, 32'd9});
        do_write(1'b0, 8'h33, 3'b111, {32'h1111_2222, 32'h3333_4444, 32'h5555_6666});
        cyc();
        do_read(8'h33, d, v);
        check_eq("rst_sweep_write_ok", d, {32'h1111_2222, 32'h3333_4444, 32'h5555_6666});
        check_eq("rst_sweep_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/moment_ram_mc.md
Name: moment_ram_mc

Overview:
- Multi-channel moment store for the LBM core. Holds NUM_CH signed moment fields per lattice node, for example rho, ux and uy.
- Generalises the single-port moment RAM with:
  - separate write and read ports;
  - a per-channel write mask;
  - an accumulate (read-modify-write) mode with optional saturation;
  - a hardware clear sweep.
- Sits between the collision/streaming datapath (writer) and the VGA/readout path (reader).

Parameters:
- DEPTH, 256, number of lattice nodes (16x16).
- ADDRESS_WIDTH, $clog2(DEPTH), address width.
- DATA_WIDTH, 32, signed width of one channel word.
- NUM_CH, 3, number of moment channels per node.
- SATURATE, 1, 1 = signed saturating accumulate; 0 = two's-complement wrap.

Ports:
- Clk  in  1  system clock, all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- clear_start  in  1  pulse: start a zero-fill sweep of all DEPTH nodes. Honoured only when busy=0.
- busy  out  1  high while the clear sweep runs.
- wr_valid  in  1  write request.
- wr_ready  out  1  equals ~busy; a write is accepted when wr_valid & wr_ready.
- wr_mode  in  1  0 = overwrite, 1 = accumulate.
- wr_addr  in  ADDRESS_WIDTH  node address.
- wr_mask  in  NUM_CH  per-channel write enable. Masked-off channels keep their value.
- wr_data  in  NUM_CH*DATA_WIDTH  packed signed words; channel c occupies bits [c*DATA_WIDTH +: DATA_WIDTH].
- rd_en  in  1  read request. Ignored while busy.
- rd_addr  in  ADDRESS_WIDTH  read address.
- rd_data  out  NUM_CH*DATA_WIDTH  read result, same packing as wr_data.
- rd_valid  out  1  high one cycle after an accepted read.
- sat_flag  out  NUM_CH  sticky flag, set when a channel's accumulate saturated.

Behaviour:
- Reset and storage:
  - Reset value of every output: busy=0, rd_valid=0, rd_data=0, sat_flag=0. wr_ready is therefore 1.
  - Reset also clears the pipeline valid bit and returns the FSM to IDLE.
  - Memory contents are not affected by Reset; only the clear sweep zeroes them.
  - Storage must infer block RAM: no reset on the array.
- Write pipeline (2 stages, both modes, so ordering is preserved):
  - S0 (accept cycle T): register addr, mode, mask and data. Issue an internal read of wr_addr.
  - S1 (cycle T+1): per masked channel compute new = mode ? old + data : data, then write at the end of T+1.
- Forwarding:
  - A write accepted at T+1 to the same address uses S1's result as its old operand, not the stale RAM output.
  - Back-to-back accumulates to one address must therefore sum correctly at full rate (1 write/cycle).
- Arithmetic:
  - Accumulate is a DATA_WIDTH+1-bit signed add.
  - SATURATE=1: clamp to +2^(DW-1)-1 or -2^(DW-1), and set sat_flag[c].
  - SATURATE=0: keep the low DW bits; sat_flag stays 0.
- Read port:
  - Synchronous, latency 1: rd_data and rd_valid are registered at T+1.
  - rd_data reflects every write accepted in cycles before T, including one still in S1 (forwarded).
  - A write accepted in the same cycle T is not visible.
  - rd_data holds its last value when rd_valid=0.
- Clear FSM, states IDLE, DRAIN, SWEEP:
  - IDLE -> DRAIN on clear_start. busy rises the next cycle; no new write is accepted from that cycle.
  - DRAIN: lasts 1 cycle and lets a pending S1 write commit.
  - SWEEP: writes zero to all channels at address 0..DEPTH-1, one address per cycle, and clears sat_flag.
  - SWEEP -> IDLE after address DEPTH-1 is written. busy falls the following cycle.
  - clear_start while busy is ignored.
  - While busy, rd_en is ignored and rd_valid=0.
  - Reset during SWEEP: abort to IDLE immediately. The memory is left partially cleared, which is acceptable.
- Simultaneous events:
  - clear_start and wr_valid in the same IDLE cycle: the write is accepted and commits in DRAIN.
  - rd_en with a same-address write in one cycle: returns the pre-write value.
- Addresses >= DEPTH (non-power-of-2 DEPTH): writes are dropped; reads return 0.

Decomposition:
- Package lbm_mem_pkg:
  - wr_mode_t enum {WR_OVERWRITE, WR_ACCUM};
  - clr_state_t enum {IDLE, DRAIN, SWEEP};
  - function sat_add(a, b) returning sum and an overflow bit.
- Sub-module moment_ram_bank: one channel, DEPTH x DATA_WIDTH, one write port and two synchronous read ports (internal RMW read, external read).
- Instantiate NUM_CH banks with a generate loop. The top level holds the S0/S1 pipeline, forwarding mux and clear FSM.

Test Plan:
- Overwrite then read:
  - Stimulus: write addr 0x12, mask 3'b111, data {0x1234_5678, 0xABCC_CDEF, 0x0000_0001}; read 0x12 two cycles later.
  - Required response: rd_data equals the written words, rd_valid for 1 cycle.
- Back-to-back accumulate with forwarding:
  - Stimulus: 4 consecutive accumulate writes of +5 to ch0 at addr 0x07 (starting value 10).
  - Required response: read returns 30, with no bubble.
- Saturation:
  - Stimulus: ch1 preset to 0x7FFF_FFF0, accumulate +0x20.
  - Required response: ch1 reads 0x7FFF_FFFF and sat_flag=3'b010.
  - Repeat with SATURATE=0: ch1 reads 0x8000_0010 and sat_flag stays 0.
- Mask:
  - Stimulus: write mask 3'b101 with all-ones data over a node holding {1,2,3}.
  - Required response: read returns {0xFFFF_FFFF, 2, 0xFFFF_FFFF}.
- Clear sweep:
  - Stimulus: clear_start with a write in flight.
  - Required response: the write commits, then busy is high for DEPTH+1 cycles. wr_ready=0 and rd_valid=0 throughout. All nodes read 0 afterwards and sat_flag=0.
- Reset mid-sweep:
  - Stimulus: assert Reset at sweep address 100.
  - Required response: busy=0 next cycle; node 50 reads 0; node 200 keeps its old value; writes accepted again.
